// File: rtl/branch_arbiter.sv
// Round-robin arbiter sharing one branch comparator between NUM_REQ requesters.
// Two-stage pipeline: operand capture, then compare and response register.

module branch_compare #(
  parameter int DATA_SIZE = 32
) (
  input  logic [2:0]           i_funct,
  input  logic [DATA_SIZE-1:0] i_r1,
  input  logic [DATA_SIZE-1:0] i_r2,
  output logic                 o_taken,
  output logic                 o_err
);

  always_comb begin
    o_taken = 1'b0;
    o_err   = 1'b0;
    case (i_funct)
      3'b000:  o_taken = (i_r1 == i_r2);
      3'b001:  o_taken = (i_r1 != i_r2);
      3'b100:  o_taken = ($signed(i_r1) <  $signed(i_r2));
      3'b101:  o_taken = ($signed(i_r1) >= $signed(i_r2));
      3'b110:  o_taken = (i_r1 <  i_r2);
      3'b111:  o_taken = (i_r1 >= i_r2);
      default: o_err   = 1'b1;
    endcase
  end

endmodule

module branch_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int DATA_SIZE = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_REQ-1:0]                 i_valid,
  input  logic [NUM_REQ-1:0][2:0]            i_funct,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  i_r1,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  i_r2,
  input  logic [NUM_REQ-1:0]                 i_flush,
  output logic [NUM_REQ-1:0]                 o_ready,
  output logic                               o_resp_valid,
  output logic [IDX_W-1:0]                   o_resp_tag,
  output logic                               o_resp_taken,
  output logic                               o_resp_err,
  output logic                               o_busy
);

  logic [IDX_W-1:0]     r_ptr;
  logic                 r_s1_valid;
  logic [2:0]           r_s1_funct;
  logic [DATA_SIZE-1:0] r_s1_r1;
  logic [DATA_SIZE-1:0] r_s1_r2;
  logic [IDX_W-1:0]     r_s1_tag;
  logic                 r_s2_valid;
  logic [IDX_W-1:0]     r_s2_tag;
  logic                 r_s2_taken;
  logic                 r_s2_err;

  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_ready;
  logic [IDX_W-1:0]     w_gnt;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_found;
  logic                 w_accept;
  logic                 w_taken;
  logic                 w_err;

  assign w_elig = i_valid & ~i_flush;

  // First eligible requester scanning upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    w_ready = '0;
    w_gnt   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
    if (w_found && !i_rst) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  assign w_accept = |w_ready;

  branch_compare #(
    .DATA_SIZE (DATA_SIZE)
  ) u_cmp (
    .i_funct (r_s1_funct),
    .i_r1    (r_s1_r1),
    .i_r2    (r_s1_r2),
    .o_taken (w_taken),
    .o_err   (w_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_funct <= '0;
      r_s1_r1    <= '0;
      r_s1_r2    <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_taken <= 1'b0;
      r_s2_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr      <= (w_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
        r_s1_funct <= i_funct[w_gnt];
        r_s1_r1    <= i_r1[w_gnt];
        r_s1_r2    <= i_r2[w_gnt];
        r_s1_tag   <= w_gnt;
      end
      r_s1_valid <= w_accept;
      // A flush aimed at the stage-1 owner kills it; stage 2 is already committed.
      r_s2_valid <= r_s1_valid & ~i_flush[r_s1_tag];
      r_s2_tag   <= r_s1_tag;
      r_s2_taken <= w_taken;
      r_s2_err   <= w_err;
    end
  end

  assign o_ready      = w_ready;
  assign o_resp_valid = r_s2_valid;
  assign o_resp_tag   = r_s2_tag;
  assign o_resp_taken = r_s2_taken;
  assign o_resp_err   = r_s2_err;
  assign o_busy       = r_s1_valid | r_s2_valid;

endmodule
